// File: rtl/alu_exec_if.sv
// Request/response bundle between the ALU control stage, alu_exec and its consumer.
// master: drives the request (in_valid, alu_op, op_a, op_b) and out_ready.
// slave:  the ALU; drives in_ready and the registered response (out_valid, result, zero, illegal).
interface alu_exec_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       alu_op;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             illegal;

  modport master (
    output in_valid, alu_op, op_a, op_b, out_ready,
    input  in_ready, out_valid, result, zero, illegal
  );

  modport slave (
    input  in_valid, alu_op, op_a, op_b, out_ready,
    output in_ready, out_valid, result, zero, illegal
  );
endinterface

// File: rtl/alu_exec.sv
// Execute-stage ALU: add/sub/logic/shift/slt, plus iterative mul/divu/remu when ALU_MULDIV_EN is defined.
// Latency: single-cycle ops 1 cycle after acceptance; mul/div WIDTH+1 cycles after acceptance.
// Backpressure: result held in DONE until out_ready; in_ready only in IDLE or DONE&&out_ready (back-to-back, no bubble).
//
// Ports: clk, rst_n (async active-low); bus (alu_exec_if.slave) carries the
// in_valid/in_ready request (alu_op, op_a, op_b) and the out_valid/out_ready
// response (result, zero, illegal).
// Optional macro ALU_MULDIV_EN: builds MUL/DIV states and the shift/add +
// restoring datapath. Undefined, codes 1000..1011 return illegal in one cycle.
module alu_exec #(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input logic       clk,
  input logic       rst_n,
  alu_exec_if.slave bus
);

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0010;
  localparam logic [3:0] OP_OR  = 4'b0011;
  localparam logic [3:0] OP_XOR = 4'b0100;
  localparam logic [3:0] OP_SLL = 4'b0101;
  localparam logic [3:0] OP_SRL = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
`ifdef ALU_MULDIV_EN
  localparam logic [3:0] OP_MULL = 4'b1000;
  localparam logic [3:0] OP_MULH = 4'b1001;
  localparam logic [3:0] OP_DIVU = 4'b1010;
  localparam logic [3:0] OP_REMU = 4'b1011;
  localparam int         CW      = $clog2(WIDTH + 1);
`endif

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DONE = 2'd1
`ifdef ALU_MULDIV_EN
    ,
    ST_MUL  = 2'd2,
    ST_DIV  = 2'd3
`endif
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] result_q;
  logic             zero_q;
  logic             illegal_q;
  logic             accept;
  logic [WIDTH-1:0] sc_res;
  logic             sc_ill;

  assign bus.in_ready  = (state == ST_IDLE) || ((state == ST_DONE) && bus.out_ready);
  assign accept        = bus.in_valid && bus.in_ready;
  assign bus.out_valid = (state == ST_DONE);
  assign bus.result    = result_q;
  assign bus.zero      = zero_q;
  assign bus.illegal   = illegal_q;

  // Single-cycle results, computed straight from the request being accepted.
  always_comb begin
    sc_res = '0;
    sc_ill = 1'b0;
    case (bus.alu_op)
      OP_ADD: sc_res = bus.op_a + bus.op_b;
      OP_SUB: sc_res = bus.op_a - bus.op_b;
      OP_AND: sc_res = bus.op_a & bus.op_b;
      OP_OR:  sc_res = bus.op_a | bus.op_b;
      OP_XOR: sc_res = bus.op_a ^ bus.op_b;
      OP_SLL: sc_res = bus.op_a << bus.op_b[SHW-1:0];
      OP_SRL: sc_res = bus.op_a >> bus.op_b[SHW-1:0];
      OP_SLT: sc_res = {{(WIDTH-1){1'b0}}, ($signed(bus.op_a) < $signed(bus.op_b))};
`ifdef ALU_MULDIV_EN
      // Handled by the iterative unit; nothing to produce here.
      OP_MULL, OP_MULH, OP_DIVU, OP_REMU: sc_res = '0;
`endif
      default: sc_ill = 1'b1;
    endcase
  end

`ifdef ALU_MULDIV_EN
  // Shared iterative datapath.
  //   MUL: hi = partial product high half, lo = multiplier (shifted out LSB first),
  //        opnd = multiplicand. After WIDTH steps {hi,lo} = a*b.
  //   DIV: hi = partial remainder, lo = dividend shifting out MSB first while
  //        quotient bits shift in, opnd = divisor. After WIDTH steps lo = q, hi = r.
  // A zero divisor never borrows, so q ends all ones and r ends equal to op_a.
  logic [WIDTH-1:0] hi, lo, opnd;
  logic [CW-1:0]    cnt;
  logic             sel_hi;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shf;
  logic [WIDTH:0]   div_dif;
  logic [WIDTH-1:0] hi_nx, lo_nx;
  logic [WIDTH-1:0] md_res;

  always_comb begin
    mul_sum = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
    div_shf = {hi, lo[WIDTH-1]};
    div_dif = div_shf - {1'b0, opnd};
    hi_nx   = hi;
    lo_nx   = lo;
    if (state == ST_MUL) begin
      hi_nx = mul_sum[WIDTH:1];
      lo_nx = {mul_sum[0], lo[WIDTH-1:1]};
    end else if (state == ST_DIV) begin
      // div_dif MSB set means the trial subtraction borrowed: restore.
      if (div_dif[WIDTH]) begin
        hi_nx = div_shf[WIDTH-1:0];
        lo_nx = {lo[WIDTH-2:0], 1'b0};
      end else begin
        hi_nx = div_dif[WIDTH-1:0];
        lo_nx = {lo[WIDTH-2:0], 1'b1};
      end
    end
    // alu_op[0] picks the high half / remainder over the low half / quotient.
    md_res = sel_hi ? hi_nx : lo_nx;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      result_q  <= '0;
      zero_q    <= 1'b0;
      illegal_q <= 1'b0;
`ifdef ALU_MULDIV_EN
      hi        <= '0;
      lo        <= '0;
      opnd      <= '0;
      cnt       <= '0;
      sel_hi    <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (accept) begin
`ifdef ALU_MULDIV_EN
            if (bus.alu_op[3:2] == 2'b10) begin
              sel_hi <= bus.alu_op[0];
              cnt    <= CW'(WIDTH);
              hi     <= '0;
              if (!bus.alu_op[1]) begin
                lo    <= bus.op_b;
                opnd  <= bus.op_a;
                state <= ST_MUL;
              end else begin
                lo    <= bus.op_a;
                opnd  <= bus.op_b;
                state <= ST_DIV;
              end
            end else
`endif
            begin
              result_q  <= sc_res;
              zero_q    <= (sc_res == '0);
              illegal_q <= sc_ill;
              state     <= ST_DONE;
            end
          end else if ((state == ST_IDLE) || bus.out_ready) begin
            state <= ST_IDLE;
          end
          // DONE without out_ready: hold everything.
        end
`ifdef ALU_MULDIV_EN
        ST_MUL, ST_DIV: begin
          hi  <= hi_nx;
          lo  <= lo_nx;
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            result_q  <= md_res;
            zero_q    <= (md_res == '0);
            illegal_q <= 1'b0;
            state     <= ST_DONE;
          end
        end
`endif
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec.sv
// Directed bench for alu_exec (WIDTH=8): vector table plus backpressure and
// mid-operation reset sequences. Expectations follow ALU_MULDIV_EN.
`timescale 1ns/1ps
module tb_alu_exec;

  localparam int WIDTH = 8;
`ifdef ALU_MULDIV_EN
  localparam bit MD = 1'b1;
`else
  localparam bit MD = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_exec_if #(.WIDTH(WIDTH)) bus ();

  alu_exec #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    string      name;
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    logic       zero;
    logic       ill;
    int         lat;
  } vec_t;

  vec_t vecs[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic vec_t mk(input string n, input logic [3:0] op, input logic [7:0] a,
                              input logic [7:0] b, input logic [7:0] res, input logic ill,
                              input int lat);
    vec_t v;
    v.name = n; v.op = op; v.a = a; v.b = b; v.res = res;
    v.zero = (res == 8'h00); v.ill = ill; v.lat = lat;
    return v;
  endfunction

  // Mul/div codes: iterative result when built in, otherwise illegal single-cycle.
  function automatic vec_t mkmd(input string n, input logic [3:0] op, input logic [7:0] a,
                                input logic [7:0] b, input logic [7:0] res);
    if (MD) return mk(n, op, a, b, res, 1'b0, WIDTH + 1);
    return mk(n, op, a, b, 8'h00, 1'b1, 1);
  endfunction

  task automatic run_vec(input vec_t v);
    int lat;
    bit rdy_bad;
    @(negedge clk);
    check({v.name, " in_ready"}, bus.in_ready, 1);
    bus.in_valid  = 1'b1;
    bus.alu_op    = v.op;
    bus.op_a      = v.a;
    bus.op_b      = v.b;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    lat = 0;
    rdy_bad = 1'b0;
    while (lat < 40) begin
      @(negedge clk);
      lat++;
      if (bus.out_valid) break;
      if (bus.in_ready) rdy_bad = 1'b1;
      // Garbage requests while busy must be neither accepted nor disturb the op.
      bus.in_valid = 1'b1;
      bus.alu_op   = 4'($urandom);
      bus.op_a     = 8'($urandom);
      bus.op_b     = 8'($urandom);
    end
    bus.in_valid = 1'b0;
    check({v.name, " latency"}, lat, v.lat);
    check({v.name, " result"}, bus.result, v.res);
    check({v.name, " zero"}, bus.zero, v.zero);
    check({v.name, " illegal"}, bus.illegal, v.ill);
    if (v.lat > 1) check({v.name, " busy in_ready"}, rdy_bad, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.alu_op    = 4'h0;
    bus.op_a      = 8'h00;
    bus.op_b      = 8'h00;
    bus.out_ready = 1'b1;

    repeat (2) @(negedge clk);
    check("reset out_valid", bus.out_valid, 0);
    check("reset result", bus.result, 0);
    check("reset zero", bus.zero, 0);
    check("reset illegal", bus.illegal, 0);
    rst_n = 1'b1;
    #1 check("reset in_ready", bus.in_ready, 1);

    vecs.push_back(mk("add F0+20", 4'b0000, 8'hF0, 8'h20, 8'h10, 1'b0, 1));
    vecs.push_back(mk("sub 05-05", 4'b0001, 8'h05, 8'h05, 8'h00, 1'b0, 1));
    vecs.push_back(mk("and F0&3C", 4'b0010, 8'hF0, 8'h3C, 8'h30, 1'b0, 1));
    vecs.push_back(mk("or 12|21",  4'b0011, 8'h12, 8'h21, 8'h33, 1'b0, 1));
    vecs.push_back(mk("xor AA^FF", 4'b0100, 8'hAA, 8'hFF, 8'h55, 1'b0, 1));
    vecs.push_back(mk("slt 80<01", 4'b0111, 8'h80, 8'h01, 8'h01, 1'b0, 1));
    vecs.push_back(mk("slt 01<80", 4'b0111, 8'h01, 8'h80, 8'h00, 1'b0, 1));
    vecs.push_back(mk("sll 01,0B", 4'b0101, 8'h01, 8'h0B, 8'h08, 1'b0, 1));
    vecs.push_back(mk("srl 80,07", 4'b0110, 8'h80, 8'h07, 8'h01, 1'b0, 1));
    vecs.push_back(mk("op 1111",   4'b1111, 8'h12, 8'h34, 8'h00, 1'b1, 1));
    vecs.push_back(mk("op 1100",   4'b1100, 8'h12, 8'h34, 8'h00, 1'b1, 1));
    vecs.push_back(mkmd("mull FFxFF", 4'b1000, 8'hFF, 8'hFF, 8'h01));
    vecs.push_back(mkmd("mulh FFxFF", 4'b1001, 8'hFF, 8'hFF, 8'hFE));
    vecs.push_back(mkmd("mull 0Dx0B", 4'b1000, 8'h0D, 8'h0B, 8'h8F));
    vecs.push_back(mkmd("mulh 0Dx0B", 4'b1001, 8'h0D, 8'h0B, 8'h00));
    vecs.push_back(mkmd("divu C8/07", 4'b1010, 8'hC8, 8'h07, 8'h1C));
    vecs.push_back(mkmd("remu C8%07", 4'b1011, 8'hC8, 8'h07, 8'h04));
    vecs.push_back(mkmd("divu 2A/00", 4'b1010, 8'h2A, 8'h00, 8'hFF));
    vecs.push_back(mkmd("remu 2A%00", 4'b1011, 8'h2A, 8'h00, 8'h2A));
    vecs.push_back(mkmd("divu 07/C8", 4'b1010, 8'h07, 8'hC8, 8'h00));
    vecs.push_back(mkmd("remu 07%C8", 4'b1011, 8'h07, 8'hC8, 8'h07));

    foreach (vecs[i]) run_vec(vecs[i]);

    // Backpressure: hold DONE for 3 cycles, then drain and accept in the same cycle.
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.alu_op    = 4'b0000;
    bus.op_a      = 8'h03;
    bus.op_b      = 8'h04;
    bus.out_ready = 1'b0;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp out_valid", bus.out_valid, 1);
      check("bp result held", bus.result, 8'h07);
      check("bp zero held", bus.zero, 0);
      check("bp illegal held", bus.illegal, 0);
      check("bp in_ready low", bus.in_ready, 0);
      bus.in_valid = 1'b1;
      bus.alu_op   = 4'b0011;
      bus.op_a     = 8'h0F;
      bus.op_b     = 8'hF0;
    end
    @(negedge clk);
    check("bp result before drain", bus.result, 8'h07);
    bus.out_ready = 1'b1;
    #1 check("bp in_ready on drain", bus.in_ready, 1);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    @(negedge clk);
    check("bp next out_valid", bus.out_valid, 1);
    check("bp next result", bus.result, 8'hFF);
    check("bp next zero", bus.zero, 0);
    check("bp next illegal", bus.illegal, 0);

    // Reset during cycle 4 of a multiply.
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.alu_op    = 4'b1000;
    bus.op_a      = 8'hFF;
    bus.op_b      = 8'hFF;
    bus.out_ready = 1'b0;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid-reset out_valid", bus.out_valid, 0);
    check("mid-reset result", bus.result, 0);
    check("mid-reset illegal", bus.illegal, 0);
    repeat (2) @(negedge clk);
    check("held-reset out_valid", bus.out_valid, 0);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    #1 check("post-reset in_ready", bus.in_ready, 1);
    run_vec(mk("post-reset add", 4'b0000, 8'h01, 8'h01, 8'h02, 1'b0, 1));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
